// File: rtl/game_flow_controller.sv
// Brick-breaker game sequencer: starts a level, paces each frame ERASE -> UPDATE -> DRAW, declares win/lose.
// Latency: one cycle per state hop; each go pulse is registered and high in the first cycle of its engine state.
// Backpressure: waits indefinitely on each engine's done; frame ticks arriving while busy are dropped and counted.
module game_flow_controller #(
  parameter int LIVES    = 3,
  parameter int HEALTH_W = 10
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                frame_tick,
  input  logic [HEALTH_W-1:0] total_health,
  input  logic                brick_hit,
  input  logic                ball_lost,
  input  logic                erase_done,
  input  logic                update_done,
  input  logic                draw_done,
  output logic                erase_go,
  output logic                update_go,
  output logic                draw_go,
  output logic                clear_screen,
  output logic [2:0]          state,
  output logic [HEALTH_W-1:0] health_left,
  output logic [1:0]          lives,
  output logic                win,
  output logic                lose,
  output logic [7:0]          overrun_cnt
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    WAIT_FRAME = 3'd2,
    ERASE      = 3'd3,
    UPDATE     = 3'd4,
    DRAW       = 3'd5,
    WIN        = 3'd6,
    LOSE       = 3'd7
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t cur;
  logic   start_q;
  logic   start_edge;
  logic   tick_taken;

  // Only a fresh press of start acts; holding the button does nothing more.
  assign start_edge = start & ~start_q;

  // A frame tick is consumed only when WAIT_FRAME actually launches a frame;
  // the WIN/LOSE exit cycle out of WAIT_FRAME drops it like any busy state.
  assign tick_taken = (cur == WAIT_FRAME) && (health_left != '0) && (lives != 2'd0);

  assign state = cur;

  // Remember last cycle's start level for edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  // Main sequencer: state plus registered one-cycle go/clear pulses and win/lose levels.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur          <= IDLE;
      erase_go     <= 1'b0;
      update_go    <= 1'b0;
      draw_go      <= 1'b0;
      clear_screen <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      erase_go     <= 1'b0;
      update_go    <= 1'b0;
      draw_go      <= 1'b0;
      clear_screen <= 1'b0;
      case (cur)
        IDLE: begin
          if (start_edge) begin
            cur          <= LOAD;
            clear_screen <= 1'b1;
          end
        end
        LOAD: begin
          cur <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          // End-of-level checks only happen here, so the last frame is always drawn.
          if (health_left == '0) begin
            cur <= WIN;
            win <= 1'b1;
          end else if (lives == 2'd0) begin
            cur  <= LOSE;
            lose <= 1'b1;
          end else if (frame_tick) begin
            cur      <= ERASE;
            erase_go <= 1'b1;
          end
        end
        ERASE: begin
          // The go flag marks the entry cycle; a done seen then is stale and ignored.
          if (erase_done && !erase_go) begin
            cur       <= UPDATE;
            update_go <= 1'b1;
          end
        end
        UPDATE: begin
          if (update_done && !update_go) begin
            cur     <= DRAW;
            draw_go <= 1'b1;
          end
        end
        DRAW: begin
          if (draw_done && !draw_go) begin
            cur <= WAIT_FRAME;
          end
        end
        WIN, LOSE: begin
          if (start_edge) begin
            cur          <= LOAD;
            clear_screen <= 1'b1;
            win          <= 1'b0;
            lose         <= 1'b0;
          end
        end
      endcase
    end
  end

  // Brick health and lives: reloaded in LOAD, consumed only by physics events during UPDATE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      health_left <= '0;
      lives       <= LIVES_INIT;
    end else if (cur == LOAD) begin
      health_left <= total_health;
      lives       <= LIVES_INIT;
    end else if (cur == UPDATE) begin
      if (brick_hit && (health_left != '0)) begin
        health_left <= health_left - HEALTH_W'(1);
      end
      if (ball_lost && (lives != 2'd0)) begin
        lives <= lives - 2'd1;
      end
    end
  end

  // Saturating count of frame ticks that could not start a frame; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun_cnt <= 8'd0;
    end else if (frame_tick && !tick_taken && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer for the brick-breaker core.
- Starts a level and paces each frame as ERASE -> UPDATE -> DRAW, handing off to the erase, physics/collision and draw engines through go/done handshakes.
- Tracks remaining brick health and player lives, and declares win or lose.
- Sits between the frame-rate timer and the per-frame datapath engines.

Parameters:
- LIVES, 3, lives loaded at level start (1..3).
- HEALTH_W, 10, width of the brick health counter.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  start/restart button level; only rising edges act
- frame_tick  in  1  one-cycle frame-rate pulse
- total_health  in  HEALTH_W  sum of all brick health for the level, sampled in LOAD
- brick_hit  in  1  one-cycle pulse, one unit of brick health removed
- ball_lost  in  1  one-cycle pulse, ball left the play field
- erase_done  in  1  erase engine finished
- update_done  in  1  physics/collision engine finished
- draw_done  in  1  draw engine finished
- erase_go  out  1  one-cycle start pulse to the erase engine
- update_go  out  1  one-cycle start pulse to the physics engine
- draw_go  out  1  one-cycle start pulse to the draw engine
- clear_screen  out  1  one-cycle pulse in LOAD
- state  out  3  current state encoding
- health_left  out  HEALTH_W  remaining brick health
- lives  out  2  remaining lives
- win  out  1  level high while in WIN
- lose  out  1  level high while in LOSE
- overrun_cnt  out  8  count of dropped frame_ticks, saturating

Behaviour:
- Reset values: state=IDLE, all go pulses=0, clear_screen=0, health_left=0, lives=LIVES, win=0, lose=0, overrun_cnt=0, internal start_q=0.
- Reset is synchronous and takes priority in any state, including mid-handshake. Done pulses after reset are ignored until the matching go is issued.
- State encoding: IDLE=0, LOAD=1, WAIT_FRAME=2, ERASE=3, UPDATE=4, DRAW=5, WIN=6, LOSE=7.
- start edge: start_edge = start & ~start_q; start_q is registered every cycle.
- All outputs are registered. Each go pulse is high exactly in the first cycle spent in its state.
- IDLE: on start_edge -> LOAD.
- LOAD (one cycle):
  - health_left <= total_health, lives <= LIVES, win=lose=0, clear_screen=1.
  - Next state is WAIT_FRAME.
- WAIT_FRAME, checks in priority order:
  - health_left==0 -> WIN (covers total_health==0).
  - lives==0 -> LOSE.
  - frame_tick -> ERASE.
  - otherwise stay.
- ERASE: erase_go=1 on the entry cycle. erase_done is ignored on the entry cycle; from the next cycle on, erase_done -> UPDATE.
- UPDATE: update_go=1 on the entry cycle; same done rule; update_done -> DRAW.
  - brick_hit in UPDATE: health_left decrements by 1, saturating at 0.
  - ball_lost in UPDATE: lives decrements by 1, saturating at 0.
  - Simultaneous brick_hit and ball_lost in the same cycle: both apply.
  - brick_hit or ball_lost arriving in any other state is ignored.
  - A pulse on the same cycle as update_done is still counted.
- DRAW: draw_go=1 on the entry cycle; same done rule; draw_done -> WAIT_FRAME.
  - Win/lose checks happen only in WAIT_FRAME, so the final frame is always drawn.
- frame_tick in any state other than WAIT_FRAME (including the cycle of the WAIT_FRAME -> WIN/LOSE transition) is dropped. Each dropped tick increments overrun_cnt, saturating at 255. overrun_cnt clears only on reset.
- WIN / LOSE: hold with win=1 (resp. lose=1). start_edge -> LOAD, clearing win/lose in LOAD.
- start held high continuously never re-triggers. start_edge in any state other than IDLE/WIN/LOSE is ignored.
- No timeout on done signals: the FSM waits indefinitely.

Test Plan:
- Reset, then start held high 5 cycles -> a single LOAD. clear_screen pulses once, health_left=total_health (e.g. 40), lives=3, state=2.
- frame_tick with done pulses returned 3 cycles after each go -> erase_go, update_go, draw_go each exactly one cycle, in order, then state=2. A done on the go cycle does not advance the FSM.
- total_health=2; two brick_hit pulses during UPDATE, plus one brick_hit during DRAW -> health_left 2->0; the DRAW hit is ignored. WIN asserted once WAIT_FRAME is re-entered after draw_done.
- ball_lost on 3 separate frames, one with a simultaneous brick_hit -> lives 3->0, health decremented by 1. LOSE after the third frame; a start edge then re-enters LOAD with lives=3, lose=0.
- frame_tick asserted during ERASE and twice during DRAW -> overrun_cnt=3, no extra frame sequence started.
- resetn low during UPDATE with update_done pending -> next cycle state=0, all outputs at reset values; a later update_done pulse has no effect.
